// File: rtl/xdisplay_ctrl_pkg.sv
// xdisplay_ctrl_pkg: shared constants and helpers for the 7-segment display controller
package xdisplay_ctrl_pkg;
   localparam int DATA_W         = 8;
   localparam int DISP_DIGITS    = 4;
   localparam int DISP_DP_BIT    = 4;
   localparam int DISP_BLANK_BIT = 5;
   localparam logic [6:0] SEG_OFF     = 7'h7F;
   localparam logic [5:0] DIGIT_BLANK = 6'b100000;
   localparam logic ST_ON  = 1'b0;
   localparam logic ST_GAP = 1'b1;
   function automatic int cnt_width(input int a, input int b);
      return $clog2(a > b ? a : b);
   endfunction
endpackage

// File: rtl/xdisplay_ctrl_seg_decode.sv
// xseg_decode: hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
module xseg_decode (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_n
);
   // Pure lookup table; segments are active low
   always_comb begin
      case (hex_i)
         4'h0: seg_n = 7'h40;
         4'h1: seg_n = 7'h79;
         4'h2: seg_n = 7'h24;
         4'h3: seg_n = 7'h30;
         4'h4: seg_n = 7'h19;
         4'h5: seg_n = 7'h12;
         4'h6: seg_n = 7'h02;
         4'h7: seg_n = 7'h78;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h10;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h03;
         4'hC: seg_n = 7'h46;
         4'hD: seg_n = 7'h21;
         4'hE: seg_n = 7'h06;
         default: seg_n = 7'h0E;
      endcase
   end
endmodule

// File: rtl/xdisplay_ctrl.sv
// xdisplay_ctrl: 4-digit multiplexed 7-segment controller with anode-off gap between digits
module xdisplay_ctrl
   import xdisplay_ctrl_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        display_sel,
   input  logic [DATA_W-1:0] data_in,
   output logic [6:0]        seg_n,
   output logic              dp_n,
   output logic [3:0]        an_n
);
   localparam int CNT_W = cnt_width(REFRESH_DIV, BLANK_CYC);

   logic [5:0]       digit_q [DISP_DIGITS];
   logic             state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d, dec_seg;
   logic             dp_q, dp_d;
   logic [5:0]       cur;
   logic             last, lit;
   logic             unused_data;

   assign unused_data = ^data_in[DATA_W-1:6];
   assign cur = digit_q[idx_q];

   xseg_decode u_dec (.hex_i(cur[3:0]), .seg_n(dec_seg));

   // Scan sequencing and next output pattern from the current slot
   always_comb begin
      last    = (state_q == ST_ON) ? (cnt_q == CNT_W'(REFRESH_DIV - 1)) : (cnt_q == CNT_W'(BLANK_CYC - 1));
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? ~state_q : state_q;
      idx_d   = (last && state_q == ST_GAP) ? idx_q + 2'd1 : idx_q;
      lit     = (state_q == ST_ON) && !cur[DISP_BLANK_BIT];
      an_d    = lit ? ~(4'b0001 << idx_q) : 4'hF;
      seg_d   = lit ? dec_seg : SEG_OFF;
      dp_d    = lit ? ~cur[DISP_DP_BIT] : 1'b1;
   end

   // Digit capture, scan state and registered outputs; reset overrides writes
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DISP_DIGITS; i++) digit_q[i] <= DIGIT_BLANK;
         state_q <= ST_GAP;
         idx_q   <= 2'd3;
         cnt_q   <= '0;
         an_q    <= 4'hF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         for (int i = 0; i < DISP_DIGITS; i++) if (display_sel[i]) digit_q[i] <= data_in[5:0];
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an_n  = an_q;
   assign seg_n = seg_q;
   assign dp_n  = dp_q;
endmodule
